rv_hazard_scoreboard: RTL

//  Parametrised hazard unit for the RV32IM pipeline. Generalises EX forwarding to NUM_RPORTS read ports and NUM_FWD stages.

---
 rtl/rv_pkg.sv | 18 +
 rtl/rv_hazard_sb.sv | 61 ++++++
 rtl/rv_hazard_scoreboard.sv | 102 ++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared register-file constants and helpers for the RV32IM hazard logic
package rv_pkg;

   localparam int RF_ADDR_W   = 5;
   localparam int NUM_RF_REGS = 32;
   localparam int FWD_SEL_ID  = 0;

   typedef logic [RF_ADDR_W-1:0] rf_addr_t;

   // One-hot over x1..x31; x0 maps to an all-zero mask so it can never become pending
   function automatic logic [NUM_RF_REGS-1:1] reg_mask(input rf_addr_t addr);
      reg_mask = '0;
      for (int r = 1; r < NUM_RF_REGS; r++) begin
         reg_mask[r] = (addr == rf_addr_t'(r));
      end
   endfunction

endpackage

// File: rtl/rv_hazard_sb.sv
// rtl/rv_hazard_sb.sv - MC write scoreboard: pending flops, age counter and sticky error flag
module rv_hazard_sb
   import rv_pkg::*;
#(
   parameter int MC_MAX_LAT = 40
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_mc_issue,
   input  rf_addr_t               i_mc_issue_waddr,
   input  logic                   i_mc_done,
   input  rf_addr_t               i_mc_done_waddr,
   output logic [NUM_RF_REGS-1:0] o_pend,
   output logic                   o_busy,
   output logic                   o_err
);

   localparam int AGE_W = $clog2(MC_MAX_LAT + 1);

   logic [NUM_RF_REGS-1:1] pend_q;
   logic [NUM_RF_REGS-1:1] pend_nxt;
   logic [AGE_W-1:0]       age_q;
   logic                   spurious_done;
   logic                   timeout;

   assign o_pend = {pend_q, 1'b0};
   assign o_busy = |pend_q;

   // Set is applied after clear so an issue and done on the same reg leaves it pending
   always_comb begin
      pend_nxt = pend_q;
      if (i_mc_done) begin
         pend_nxt = pend_nxt & ~reg_mask(i_mc_done_waddr);
      end
      if (i_mc_issue) begin
         pend_nxt = pend_nxt | reg_mask(i_mc_issue_waddr);
      end
   end

   assign spurious_done = i_mc_done && !o_pend[i_mc_done_waddr];
   assign timeout       = o_busy && !i_mc_done && (age_q == AGE_W'(MC_MAX_LAT));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pend_q <= '0;
         age_q  <= '0;
         o_err  <= 1'b0;
      end else begin
         pend_q <= pend_nxt;
         if (i_mc_issue || !o_busy) begin
            age_q <= '0;
         end else if (age_q != AGE_W'(MC_MAX_LAT)) begin
            age_q <= age_q + AGE_W'(1);
         end
         if ((i_mc_issue && o_busy) || spurious_done || timeout) begin
            o_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/rv_hazard_scoreboard.sv
// rtl/rv_hazard_scoreboard.sv - RV32IM hazard unit: EX/ID bypass select, stall generation, stall counter
module rv_hazard_scoreboard
   import rv_pkg::*;
#(
   parameter int NUM_RPORTS = 2,
   parameter int NUM_FWD    = 2,
   parameter int MC_MAX_LAT = 40,
   parameter int CNT_W      = 32,
   localparam int SEL_W     = $clog2(NUM_FWD + 1)
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic [NUM_RPORTS-1:0][RF_ADDR_W-1:0]  i_haz_rf_raddr_id,
   input  logic [NUM_RPORTS-1:0]                 i_haz_rf_ren_id,
   input  logic [RF_ADDR_W-1:0]                  i_haz_rf_waddr_id,
   input  logic                                  i_haz_rf_wen_id,
   input  logic                                  i_haz_is_mc_id,
   input  logic [NUM_RPORTS-1:0][RF_ADDR_W-1:0]  i_haz_rf_raddr_ex,
   input  logic [NUM_FWD-1:0][RF_ADDR_W-1:0]     i_haz_rf_waddr_fwd,
   input  logic [NUM_FWD-1:0]                    i_haz_rf_wen_fwd,
   input  logic [NUM_FWD-1:0]                    i_haz_fwd_rdy,
   input  logic                                  i_haz_mc_issue,
   input  logic [RF_ADDR_W-1:0]                  i_haz_mc_issue_waddr,
   input  logic                                  i_haz_mc_done,
   input  logic [RF_ADDR_W-1:0]                  i_haz_mc_done_waddr,
   output logic [NUM_RPORTS-1:0]                 o_haz_rf_rdata_sel_id,
   output logic [NUM_RPORTS-1:0][SEL_W-1:0]      o_haz_fwd_sel_ex,
   output logic                                  o_haz_stall_ex,
   output logic                                  o_haz_stall_id,
   output logic                                  o_haz_mc_busy,
   output logic [CNT_W-1:0]                      o_haz_stall_cnt,
   output logic                                  o_haz_sb_err
);

   logic [NUM_RF_REGS-1:0] pend;
   logic                   raw_hit;
   logic                   waw_hit;

   rv_hazard_sb #(
      .MC_MAX_LAT (MC_MAX_LAT)
   ) u_sb (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_mc_issue       (i_haz_mc_issue),
      .i_mc_issue_waddr (i_haz_mc_issue_waddr),
      .i_mc_done        (i_haz_mc_done),
      .i_mc_done_waddr  (i_haz_mc_done_waddr),
      .o_pend           (pend),
      .o_busy           (o_haz_mc_busy),
      .o_err            (o_haz_sb_err)
   );

   // Scan oldest to nearest so the nearest matching stage overwrites and wins
   always_comb begin
      for (int p = 0; p < NUM_RPORTS; p++) begin
         o_haz_fwd_sel_ex[p] = SEL_W'(FWD_SEL_ID);
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (i_haz_rf_wen_fwd[k] && (i_haz_rf_waddr_fwd[k] != '0) &&
                (i_haz_rf_waddr_fwd[k] == i_haz_rf_raddr_ex[p])) begin
               o_haz_fwd_sel_ex[p] = SEL_W'(k + 1);
            end
         end
      end
   end

   always_comb begin
      o_haz_stall_ex = 1'b0;
      for (int p = 0; p < NUM_RPORTS; p++) begin
         for (int k = 0; k < NUM_FWD; k++) begin
            if ((o_haz_fwd_sel_ex[p] == SEL_W'(k + 1)) && !i_haz_fwd_rdy[k]) begin
               o_haz_stall_ex = 1'b1;
            end
         end
      end
   end

   always_comb begin
      o_haz_rf_rdata_sel_id = '0;
      raw_hit               = 1'b0;
      for (int p = 0; p < NUM_RPORTS; p++) begin
         o_haz_rf_rdata_sel_id[p] = i_haz_rf_wen_fwd[NUM_FWD-1] &&
                                    (i_haz_rf_waddr_fwd[NUM_FWD-1] != '0) &&
                                    (i_haz_rf_waddr_fwd[NUM_FWD-1] == i_haz_rf_raddr_id[p]);
         if (i_haz_rf_ren_id[p] && pend[i_haz_rf_raddr_id[p]]) begin
            raw_hit = 1'b1;
         end
      end
   end

   assign waw_hit        = i_haz_rf_wen_id && pend[i_haz_rf_waddr_id];
   assign o_haz_stall_id = o_haz_stall_ex || raw_hit || waw_hit ||
                           (i_haz_is_mc_id && o_haz_mc_busy);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_haz_stall_cnt <= '0;
      end else if ((o_haz_stall_id || o_haz_stall_ex) && (o_haz_stall_cnt != '1)) begin
         o_haz_stall_cnt <= o_haz_stall_cnt + CNT_W'(1);
      end
   end

endmodule
